// File: rtl/adder_share_arbiter_if.sv
// Requester/consumer bundle for adder_share_arbiter.
// rsp_carry exists only when ADD_ARB_CARRY_EN is defined.
interface adder_share_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [W-1:0]      rsp_sum;
  logic [IDW-1:0]    rsp_id;
  logic              busy;
`ifdef ADD_ARB_CARRY_EN
  logic              rsp_carry;
`endif

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_id, busy
`ifdef ADD_ARB_CARRY_EN
    , input rsp_carry
`endif
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_id, busy
`ifdef ADD_ARB_CARRY_EN
    , output rsp_carry
`endif
  );
endinterface

// File: rtl/adder_share_arbiter.sv
// One registered W-bit adder shared round-robin between NREQ requesters.
// Define ADD_ARB_CARRY_EN to add the rsp_carry output (bit W of a+b).
module adder_share_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  adder_share_arbiter_if.slave  bus
);
  localparam int IDW = $clog2(NREQ);
  localparam int PW  = IDW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t         state_reg, state_next;
  logic [IDW-1:0] rr_ptr_reg, rr_ptr_next;
  logic [W-1:0]   a_reg, b_reg;
  logic [IDW-1:0] id_reg;
  logic [W-1:0]   sum_reg;
  logic [IDW-1:0] rsp_id_reg;
`ifdef ADD_ARB_CARRY_EN
  logic           carry_reg;
  logic [W:0]     full_sum;
`else
  logic [W-1:0]   full_sum;
`endif

  logic [W-1:0]   req_a_arr [NREQ];
  logic [W-1:0]   req_b_arr [NREQ];
  logic [PW-1:0]  cand_raw  [NREQ];
  logic [IDW-1:0] cand_idx  [NREQ];
  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  logic [NREQ-1:0] grant_vec;
  logic           capture;

  // cand_idx[gi] is the requester examined at search position gi, starting at rr_ptr.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      assign req_a_arr[gi] = bus.req_a[gi*W +: W];
      assign req_b_arr[gi] = bus.req_b[gi*W +: W];
      assign cand_raw[gi]  = {1'b0, rr_ptr_reg} + PW'(gi);
      assign cand_idx[gi]  = (cand_raw[gi] >= PW'(NREQ))
                             ? IDW'(cand_raw[gi] - PW'(NREQ))
                             : cand_raw[gi][IDW-1:0];
    end
  endgenerate

  // Scan from the far end so the position nearest rr_ptr wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req_valid[cand_idx[k]]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx[k];
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
    grant_vec   = '0;
    capture     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (grant_found) begin
          grant_vec[grant_idx] = 1'b1;
          capture              = 1'b1;
          rr_ptr_next          = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
          state_next           = EXEC;
        end
      end
      EXEC:    state_next = RESP;
      RESP:    if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef ADD_ARB_CARRY_EN
  assign full_sum = {1'b0, a_reg} + {1'b0, b_reg};
`else
  assign full_sum = a_reg + b_reg;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      id_reg     <= '0;
      sum_reg    <= '0;
      rsp_id_reg <= '0;
`ifdef ADD_ARB_CARRY_EN
      carry_reg  <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      if (capture) begin
        a_reg  <= req_a_arr[grant_idx];
        b_reg  <= req_b_arr[grant_idx];
        id_reg <= grant_idx;
      end
      if (state_reg == EXEC) begin
        sum_reg    <= full_sum[W-1:0];
        rsp_id_reg <= id_reg;
`ifdef ADD_ARB_CARRY_EN
        carry_reg  <= full_sum[W];
`endif
      end
    end
  end

  assign bus.req_ready = grant_vec;
  assign bus.rsp_valid = (state_reg == RESP);
  assign bus.rsp_sum   = sum_reg;
  assign bus.rsp_id    = rsp_id_reg;
  assign bus.busy      = (state_reg != IDLE);
`ifdef ADD_ARB_CARRY_EN
  assign bus.rsp_carry = carry_reg;
`endif
endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one registered W-bit adder between NREQ requesters.
- Each requester presents an operand pair with a valid/ready handshake.
- A round-robin arbiter grants one requester per operation. A 3-state sequencer captures operands, computes the sum, and holds the result with the requester ID until the consumer accepts it.
- Sits between the ui_in-driven operand sources and the uo_out result path of the top level.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 4, operand and sum width in bits.
- IDW, $clog2(NREQ), width of the requester ID (derived localparam, not overridable).

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  bit i: requester i has an operand pair pending.
- req_ready  output  NREQ  one-hot grant/accept strobe; bit i high for exactly the cycle requester i's operands are captured.
- req_a  input  NREQ*W  operand A of requester i at bits [i*W +: W].
- req_b  input  NREQ*W  operand B of requester i at bits [i*W +: W].
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_sum  output  W  registered sum, modulo 2^W.
- rsp_id  output  IDW  index of the requester that owns rsp_sum.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- States: IDLE, EXEC, RESP. Encoding is free; busy = (state != IDLE).
- Reset (sampled on clk edge while reset=1):
  - state=IDLE; rr_ptr=0; operand and result registers = 0.
  - req_ready=0, rsp_valid=0, rsp_sum=0, rsp_id=0, busy=0.
  - Reset mid-operation aborts the operation; the in-flight result is discarded and never presented.
- IDLE:
  - If req_valid != 0, select the first set bit searching from rr_ptr upward, wrapping modulo NREQ.
  - Drive req_ready[g]=1 combinationally in that cycle only. A transfer occurs when req_valid[g] & req_ready[g].
  - Capture req_a[g], req_b[g] and g into internal registers; rr_ptr <= (g+1) mod NREQ; next state EXEC.
  - If req_valid == 0: stay in IDLE; rr_ptr unchanged.
- req_ready is 0 in EXEC and RESP, and in IDLE for every non-granted bit.
- EXEC (one cycle): rsp_sum <= (a + b) truncated to W bits; rsp_id <= captured g; next state RESP.
- RESP:
  - rsp_valid=1; rsp_sum and rsp_id held stable.
  - On rsp_ready=1: transfer completes, next state IDLE. Otherwise stay in RESP indefinitely (backpressure).
- Latency:
  - Accept at cycle N, rsp_valid high from cycle N+2.
  - Minimum issue interval 3 cycles (IDLE, EXEC, RESP each at least 1 cycle).
- Fairness: with all NREQ requesters continuously valid, grants rotate 0,1,2,...,NREQ-1,0. No requester waits more than NREQ-1 other grants.
- A requester dropping req_valid before being granted is legal; no state change results.
- req_valid changes while the block is busy are ignored until the next IDLE cycle.
- rsp_ready asserted outside RESP is ignored.
- Sum wrap: 0xF + 0x1 = 0x0 at W=4; the carry is discarded unless the optional feature is enabled.

Optional Feature:
- Macro: ADD_ARB_CARRY_EN.
- Defined:
  - Extra output port rsp_carry (1 bit) = bit W of the (W+1)-bit sum a+b.
  - Registered in EXEC alongside rsp_sum and held through RESP.
  - Reset value 0.
- Not defined:
  - Port rsp_carry does not exist.
  - Adder is W bits wide; carry is dropped; no other behaviour changes.

Test Plan:
- Reset mid-op: accept req 0 (a=3,b=4); assert reset during EXEC -> next cycle state IDLE, rsp_valid=0, rsp_sum=0, rr_ptr=0, busy=0; no response ever emitted.
- Single requester: req_valid=4'b0100, a2=5, b2=6 -> req_ready=4'b0100 for 1 cycle; 2 cycles later rsp_valid=1, rsp_sum=11, rsp_id=2; rsp_ready=1 -> rsp_valid=0 next cycle.
- Round-robin: req_valid=4'b1111 held, rsp_ready=1 held -> grant order 0,1,2,3,0; each grant 3 cycles apart; rsp_id sequence matches.
- Wrap/skip: after grant to 3, req_valid=4'b0011 -> grant 0, then 1; with only bit 2 set after grant 2 -> grant 2 again.
- Backpressure: result pending, rsp_ready=0 for 5 cycles while req_valid=4'b1111 -> rsp_sum/rsp_id stable, req_ready=0 throughout, busy=1; rsp_ready=1 -> IDLE, next grant follows rr_ptr.
- Overflow: a=0xF, b=0x1 -> rsp_sum=0x0; with ADD_ARB_CARRY_EN rsp_carry=1. a=0x7, b=0x8 -> rsp_sum=0xF, rsp_carry=0.
